// File: rtl/reg_bank_arb_pkg.sv
// Shared types and helpers for the configuration register bank arbiter.
//   state_t     : access FSM states (IDLE -> ACCESS -> RESP)
//   owner_t     : which requester owns the current access
//   calc_addr_w : request address width covering config + status ranges
package reg_bank_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_t;

   function automatic int calc_addr_w(input int num_cfg, input int num_status);
      return $clog2(num_cfg + num_status);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker with an optional sticky lock for requester B.
// Ports:
//   clk, rstb   : clock, asynchronous active-low reset
//   ena         : clock enable, state holds when low
//   req_a_i     : requester A pending
//   req_b_i     : requester B pending
//   lock_b_i    : B asks to keep ownership after this win (tie low if unused)
//   take_i      : the owner FSM is ready to accept a winner this cycle
//   valid_o     : a winner exists this cycle
//   winner_o    : the winning requester
module rr_arb2
   import reg_bank_arb_pkg::*;
(
   input  logic   clk,
   input  logic   rstb,
   input  logic   ena,
   input  logic   req_a_i,
   input  logic   req_b_i,
   input  logic   lock_b_i,
   input  logic   take_i,
   output logic   valid_o,
   output owner_t winner_o
);

   owner_t last_q, last_d;
   logic   lock_q, lock_d;

   // While locked only B can win; A stays pending.
   always_comb begin
      valid_o  = 1'b0;
      winner_o = OWN_A;
      if (lock_q) begin
         valid_o  = req_b_i;
         winner_o = OWN_B;
      end else if (req_a_i && req_b_i) begin
         valid_o  = 1'b1;
         winner_o = (last_q == OWN_B) ? OWN_A : OWN_B;
      end else if (req_a_i) begin
         valid_o  = 1'b1;
         winner_o = OWN_A;
      end else if (req_b_i) begin
         valid_o  = 1'b1;
         winner_o = OWN_B;
      end
   end

   // The lock is re-evaluated on every B win, so a B access with lock low releases it.
   always_comb begin
      last_d = last_q;
      lock_d = lock_q;
      if (take_i && valid_o) begin
         last_d = winner_o;
         lock_d = (winner_o == OWN_B) && lock_b_i;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         last_q <= OWN_B;
         lock_q <= 1'b0;
      end else if (ena) begin
         last_q <= last_d;
         lock_q <= lock_d;
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Configuration register bank shared between the SPI slave (port A) and an
// on-chip sequencer/self-test engine (port B). One access at a time, round-robin,
// fixed timing: request seen in IDLE -> gnt next cycle (ACCESS) -> rvalid the
// cycle after (RESP).
// Addresses [0, NUM_CFG) hit the config registers (read/write); addresses
// [NUM_CFG, NUM_CFG+NUM_STATUS) read the status vector, writes there are
// dropped and flagged with err.
// Ports:
//   clk, rstb            : clock, asynchronous active-low reset
//   ena                  : clock enable, everything freezes when low
//   a_* / b_*            : requester ports (req/we/addr/wdata in,
//                          gnt/rvalid/rdata/err out)
//   b_lock               : only with REG_BANK_ARB_LOCK_EN; B keeps ownership
//                          while it wins with b_lock high
//   status_regs          : flat status input, reg i at [i*REG_WIDTH +: REG_WIDTH]
//   config_regs          : flat config output, same packing
// Optional feature macro: REG_BANK_ARB_LOCK_EN.
module reg_bank_arbiter
   import reg_bank_arb_pkg::*;
#(
   parameter  int NUM_CFG    = 16,
   parameter  int NUM_STATUS = 16,
   parameter  int REG_WIDTH  = 8,
   localparam int ADDR_W     = calc_addr_w(NUM_CFG, NUM_STATUS)
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic                            ena,
   input  logic                            a_req,
   input  logic                            a_we,
   input  logic [ADDR_W-1:0]               a_addr,
   input  logic [REG_WIDTH-1:0]            a_wdata,
   output logic                            a_gnt,
   output logic                            a_rvalid,
   output logic [REG_WIDTH-1:0]            a_rdata,
   output logic                            a_err,
   input  logic                            b_req,
`ifdef REG_BANK_ARB_LOCK_EN
   input  logic                            b_lock,
`endif
   input  logic                            b_we,
   input  logic [ADDR_W-1:0]               b_addr,
   input  logic [REG_WIDTH-1:0]            b_wdata,
   output logic                            b_gnt,
   output logic                            b_rvalid,
   output logic [REG_WIDTH-1:0]            b_rdata,
   output logic                            b_err,
   input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
   output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs
);

   localparam int CIDX_W = $clog2(NUM_CFG);

   state_t                state_q, state_d;
   owner_t                owner_q, owner_d;
   logic                  we_q, we_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [REG_WIDTH-1:0]  wdata_q, wdata_d;

   logic [NUM_CFG-1:0][REG_WIDTH-1:0] cfg_q;
   logic [REG_WIDTH-1:0]  a_rdata_q, b_rdata_q;
   logic                  a_err_q, b_err_q;

   logic                  arb_valid;
   owner_t                arb_winner;
   logic                  lock_in;
   logic                  in_cfg;
   logic [CIDX_W-1:0]     idx;
   logic [REG_WIDTH-1:0]  acc_data;

`ifdef REG_BANK_ARB_LOCK_EN
   assign lock_in = b_lock;
`else
   assign lock_in = 1'b0;
`endif

   rr_arb2 u_arb (
      .clk      (clk),
      .rstb     (rstb),
      .ena      (ena),
      .req_a_i  (a_req),
      .req_b_i  (b_req),
      .lock_b_i (lock_in),
      .take_i   (state_q == IDLE),
      .valid_o  (arb_valid),
      .winner_o (arb_winner)
   );

   // Config and status banks are the same power-of-2 size, so the low bits
   // index either bank directly (status index = addr - NUM_CFG).
   assign in_cfg = (addr_q < ADDR_W'(NUM_CFG));
   assign idx    = addr_q[CIDX_W-1:0];

   // Writes echo the written value back, even when dropped as an error.
   always_comb begin
      acc_data = wdata_q;
      if (!we_q) begin
         acc_data = in_cfg ? cfg_q[idx] : status_regs[int'(idx)*REG_WIDTH +: REG_WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               owner_d = arb_winner;
               state_d = ACCESS;
               if (arb_winner == OWN_B) begin
                  we_d    = b_we;
                  addr_d  = b_addr;
                  wdata_d = b_wdata;
               end else begin
                  we_d    = a_we;
                  addr_d  = a_addr;
                  wdata_d = a_wdata;
               end
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         owner_q <= OWN_A;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (ena) begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Bank update and response capture both happen at the end of ACCESS, so a
   // reset during ACCESS leaves no trace of the access.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cfg_q <= '0;
      end else if (ena && state_q == ACCESS && we_q && in_cfg) begin
         cfg_q[idx] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
      end else if (ena && state_q == ACCESS) begin
         if (owner_q == OWN_A) begin
            a_rdata_q <= acc_data;
            a_err_q   <= we_q && !in_cfg;
         end else begin
            b_rdata_q <= acc_data;
            b_err_q   <= we_q && !in_cfg;
         end
      end
   end

   // Strobes decode straight from registered state, so they stretch while ena is low.
   assign a_gnt       = (state_q == ACCESS) && (owner_q == OWN_A);
   assign b_gnt       = (state_q == ACCESS) && (owner_q == OWN_B);
   assign a_rvalid    = (state_q == RESP)   && (owner_q == OWN_A);
   assign b_rvalid    = (state_q == RESP)   && (owner_q == OWN_B);
   assign a_rdata     = a_rdata_q;
   assign b_rdata     = b_rdata_q;
   assign a_err       = a_err_q;
   assign b_err       = b_err_q;
   assign config_regs = cfg_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: stimulus pushes hand-computed expected
// responses per port; a monitor pops and compares on every rvalid.
module tb_reg_bank_arbiter;

   localparam int NC = 16;
   localparam int NS = 16;
   localparam int W  = 8;
   localparam int AW = 5;

   typedef struct packed {
      logic [W-1:0] rdata;
      logic         err;
   } resp_t;

   logic           clk  = 1'b0;
   logic           rstb = 1'b1;
   logic           ena  = 1'b1;
   logic           a_req = 1'b0, a_we = 1'b0;
   logic [AW-1:0]  a_addr = '0;
   logic [W-1:0]   a_wdata = '0;
   logic           b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0]  b_addr = '0;
   logic [W-1:0]   b_wdata = '0;
   logic           b_lock = 1'b0;
   logic           a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
   logic [W-1:0]   a_rdata, b_rdata;
   logic [NS*W-1:0] status_regs = '0;
   logic [NC*W-1:0] config_regs;
   logic [NC*W-1:0] cfg_model = '0;

   resp_t qa[$];
   resp_t qb[$];
   resp_t ea, eb;
   int    checks = 0;
   int    errors = 0;
   int    bcnt = 0;

   reg_bank_arbiter dut (
      .clk(clk), .rstb(rstb), .ena(ena),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req),
`ifdef REG_BANK_ARB_LOCK_EN
      .b_lock(b_lock),
`endif
      .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
      .status_regs(status_regs), .config_regs(config_regs)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: responses are consumed on the cycle the RESP state retires.
   always @(negedge clk) begin
      if (rstb) begin
         chk("no_dual_strobe", {a_gnt & b_gnt, a_rvalid & b_rvalid}, 2'b00);
         if (ena && a_rvalid) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected_rvalid: got rdata %0h with no expected response", a_rdata);
            end else begin
               ea = qa.pop_front();
               chk("a_rdata", a_rdata, ea.rdata);
               chk("a_err", a_err, ea.err);
            end
         end
         if (ena && b_rvalid) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected_rvalid: got rdata %0h with no expected response", b_rdata);
            end else begin
               eb = qb.pop_front();
               chk("b_rdata", b_rdata, eb.rdata);
               chk("b_err", b_err, eb.err);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one access and follow the handshake; exp_lat > 0 also checks the
   // number of cycles from request to grant.
   task automatic acc(input bit pb, input bit we, input logic [AW-1:0] addr,
                      input logic [W-1:0] wd, input bit lock, input int exp_lat);
      int n = 0;
      if (pb) begin
         b_we = we; b_addr = addr; b_wdata = wd; b_lock = lock; b_req = 1'b1;
      end else begin
         a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
      end
      do begin
         cyc(1);
         n++;
      end while (!(pb ? b_gnt : a_gnt) && n < 60);
      chk(pb ? "b_gnt_seen" : "a_gnt_seen", pb ? b_gnt : a_gnt, 1'b1);
      if (exp_lat > 0) chk("gnt_latency", n, exp_lat);
      if (pb) b_req = 1'b0; else a_req = 1'b0;
      cyc(1);
      chk(pb ? "b_rvalid_next" : "a_rvalid_next", {pb ? b_rvalid : a_rvalid, pb ? b_gnt : a_gnt}, 2'b10);
   endtask

   initial begin
      int gcnt;
      int ng;
      int gcyc[4];
      bit gown[4];
      for (int i = 0; i < NS; i++)
         status_regs[i*W +: W] = (i == 0) ? 8'hCA : 8'(8'h60 + i);

      // Reset state
      #2 rstb = 1'b0;
      cyc(2);
      chk("rst_strobes", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err}, 6'b0);
      chk("rst_rdata", {a_rdata, b_rdata}, 16'h0);
      chk("rst_config", config_regs, '0);
      rstb = 1'b1;
      cyc(1);

      // Port A write then read back, isolated accesses: gnt 1 cycle after req
      qa.push_back('{rdata: 8'h3C, err: 1'b0});
      acc(0, 1, 5'd0, 8'h3C, 0, 1);
      cfg_model[7:0] = 8'h3C;
      chk("cfg0_written", config_regs, cfg_model);
      cyc(1);
      qa.push_back('{rdata: 8'h3C, err: 1'b0});
      acc(0, 0, 5'd0, 8'h00, 0, 1);
      cyc(1);

      // Port B: status read, write into status range flagged and dropped
      qb.push_back('{rdata: 8'hCA, err: 1'b0});
      acc(1, 0, 5'd16, 8'h00, 0, 1);
      qb.push_back('{rdata: 8'h11, err: 1'b1});
      acc(1, 1, 5'd17, 8'h11, 0, 2);
      chk("status_write_dropped", config_regs, cfg_model);

      // Range boundaries: last config reg, last status reg, unwritten reg
      qa.push_back('{rdata: 8'hA5, err: 1'b0});
      acc(0, 1, 5'd15, 8'hA5, 0, 2);
      cfg_model[15*W +: W] = 8'hA5;
      chk("cfg15_written", config_regs, cfg_model);
      qb.push_back('{rdata: 8'h6F, err: 1'b0});
      acc(1, 0, 5'd31, 8'h00, 0, 2);
      qb.push_back('{rdata: 8'hA5, err: 1'b0});
      acc(1, 0, 5'd15, 8'h00, 0, 2);
      qa.push_back('{rdata: 8'h00, err: 1'b0});
      acc(0, 0, 5'd5, 8'h00, 0, 2);
      cyc(1);

      // ena low for 4 cycles during ACCESS: gnt stretches to 5 cycles
      qa.push_back('{rdata: 8'h5A, err: 1'b0});
      a_we = 1'b1; a_addr = 5'd3; a_wdata = 8'h5A; a_req = 1'b1;
      cyc(1);
      chk("ena_gnt_start", a_gnt, 1'b1);
      a_req = 1'b0;
      ena = 1'b0;
      gcnt = 1;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         if (a_gnt) gcnt++;
         chk("ena_no_rvalid", a_rvalid, 1'b0);
      end
      chk("ena_cfg_frozen", config_regs, cfg_model);
      ena = 1'b1;
      cyc(1);
      chk("ena_gnt_cycles", gcnt, 5);
      chk("ena_rvalid_after", {a_rvalid, a_gnt}, 2'b10);
      cfg_model[3*W +: W] = 8'h5A;
      chk("ena_write_once", config_regs, cfg_model);
      cyc(1);

      // Reset during ACCESS of a write abandons it
      a_we = 1'b1; a_addr = 5'd2; a_wdata = 8'hFF; a_req = 1'b1;
      cyc(1);
      chk("rst_mid_gnt", a_gnt, 1'b1);
      a_req = 1'b0;
      rstb = 1'b0;
      #1;
      cfg_model = '0;
      chk("rst_mid_config", config_regs, cfg_model);
      chk("rst_mid_outputs", {a_gnt, a_rvalid, a_err, a_rdata}, 11'h0);
      cyc(1);
      rstb = 1'b1;
      cyc(1);
      chk("rst_mid_idle", {a_gnt, a_rvalid, b_gnt, b_rvalid}, 4'b0);
      chk("rst_mid_no_write", config_regs, cfg_model);

      // Continuous contention from reset: A,B,A,B, 3 cycles apart
      for (int i = 0; i < 2; i++) begin
         qa.push_back('{rdata: 8'h61, err: 1'b0});
         qb.push_back('{rdata: 8'h62, err: 1'b0});
      end
      a_we = 1'b0; a_addr = 5'd17; a_req = 1'b1;
      b_we = 1'b0; b_addr = 5'd18; b_req = 1'b1;
      ng = 0;
      for (int c = 1; c <= 30 && ng < 4; c++) begin
         cyc(1);
         if (a_gnt || b_gnt) begin
            gcyc[ng] = c;
            gown[ng] = b_gnt;
            ng++;
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("rr_grant_count", ng, 4);
      chk("rr_first_latency", gcyc[0], 1);
      for (int k = 0; k < 4; k++) begin
         chk("rr_owner", gown[k], k[0]);
         if (k > 0) chk("rr_spacing", gcyc[k] - gcyc[k-1], 3);
      end
      cyc(3);

`ifdef REG_BANK_ARB_LOCK_EN
      // B locks across three writes while A waits
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               qb.push_back('{rdata: 8'(8'h20 + k), err: 1'b0});
               acc(1, 1, 5'(4 + k), 8'(8'h20 + k), (k < 2), 0);
               bcnt++;
            end
         end
         begin
            cyc(1);
            qa.push_back('{rdata: 8'h20, err: 1'b0});
            acc(0, 0, 5'd4, 8'h00, 0, 0);
            chk("lock_a_after_b", bcnt, 3);
         end
      join
      cfg_model[4*W +: 3*W] = 24'h222120;
      chk("lock_cfg", config_regs, cfg_model);
`endif

      cyc(5);
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Owns the configuration register bank and shares it between two requesters:
- Port A: the SPI slave core.
- Port B: an on-chip sequencer or self-test engine.

Round-robin arbitration, one access at a time, fixed 2-cycle access latency. Presents the flat config_regs vector to the top level and muxes the flat status_regs vector into read data.

Parameters:
NUM_CFG, 16, number of config registers (power of 2)
NUM_STATUS, 16, number of status registers (must equal NUM_CFG)
REG_WIDTH, 8, register width in bits
ADDR_W, $clog2(NUM_CFG+NUM_STATUS), request address width (derived, not overridable)

Ports:
clk  input  1  system clock
rstb  input  1  asynchronous active-low reset
ena  input  1  clock enable; when low all state holds
a_req  input  1  port A request, held until a_gnt
a_we  input  1  port A write (1) / read (0)
a_addr  input  ADDR_W  port A address
a_wdata  input  REG_WIDTH  port A write data
a_gnt  output  1  port A grant pulse
a_rvalid  output  1  port A response pulse
a_rdata  output  REG_WIDTH  port A read data
a_err  output  1  port A error, qualified by a_rvalid
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err  (as port A, port B)
status_regs  input  NUM_STATUS*REG_WIDTH  flat status vector, reg i at [i*REG_WIDTH +: REG_WIDTH]
config_regs  output  NUM_CFG*REG_WIDTH  flat config vector, same packing

Behaviour:
- Clock and reset: one clock (clk). rstb is asynchronous, active-low.
- Reset values:
  - FSM=IDLE, last_grant=B (A wins the first tie).
  - All gnt/rvalid/err = 0, all rdata = 0.
  - config_regs = 0.
- FSM states are IDLE, ACCESS, RESP.
- IDLE:
  - Samples a_req/b_req.
  - If none, stay.
  - If one, latch its we/addr/wdata and owner, then go to ACCESS.
  - If both, grant the port not equal to last_grant; update last_grant.
- ACCESS (1 cycle):
  - Owner gnt = 1.
  - Write with addr < NUM_CFG: the config reg is updated at the end of this cycle.
  - Write with addr >= NUM_CFG: no state change; err flagged.
  - Read: captures config[addr] if addr < NUM_CFG, else status[addr-NUM_CFG].
  - Next state is RESP.
- RESP (1 cycle):
  - Owner rvalid = 1.
  - rdata holds the captured data; for writes, rdata = written value.
  - err = 1 for a write to the status range.
  - Next state is IDLE.
- rdata holds its value until the next response to that port.
- Latency: req seen in IDLE at cycle n gives gnt at n+1 and rvalid at n+2. The next grant can come no earlier than n+3. Throughput is 1 access per 3 cycles.
- Handshake:
  - Requester holds req and payload stable until it sees gnt, then deasserts req by the next cycle.
  - req is sampled only in IDLE, so req still high during RESP is not a new request.
  - Payload changes while waiting (not granted) are allowed; the latched values are the ones present in the IDLE cycle that wins.
- The losing requester waits, at most one access (3 cycles) under continuous contention.
- ena low: FSM, outputs and registers freeze. gnt/rvalid pulses stretch for as long as ena stays low.
- Reset mid-access: abandons the access with no partial write, and all outputs return to reset values.
- Only the owner's gnt/rvalid ever assert; the two ports never both assert.

Optional Feature:
Macro REG_BANK_ARB_LOCK_EN.
- Enabled:
  - Adds input b_lock.
  - If b_lock = 1 in the IDLE cycle in which B wins, B keeps ownership and A is not granted until B issues an access with b_lock = 0.
  - A requests stay pending throughout.
  - Lock is dropped on reset.
- Disabled: port absent; pure round-robin.

Decomposition:
- Package reg_bank_arb_pkg holds:
  - typedef state_t {IDLE, ACCESS, RESP};
  - typedef owner_t {OWN_A, OWN_B};
  - the helper function computing ADDR_W.
- One natural sub-module, rr_arb2: 2-input round-robin picker with last_grant register and optional lock input. The register storage and FSM stay in the top module.

Test Plan:
- Write 0x3C to addr 0 via A, then read addr 0 via A -> a_gnt at n+1, a_rvalid at n+2, a_rdata=0x3C, config_regs[7:0]=0x3C, a_err=0.
- B reads addr 16 with status_regs[7:0]=0xCA -> b_rdata=0xCA, b_err=0; B writes 0x11 to addr 17 -> b_err=1 on b_rvalid, no config change.
- A and B both request in the same cycle from reset, held continuously -> grants alternate A,B,A,B; each gnt is 3 cycles apart; no double grant.
- ena low during ACCESS for 4 cycles -> gnt stays high 5 cycles, write lands once, rvalid follows after ena returns.
- rstb low during ACCESS of a write of 0xFF to addr 2 -> config_regs all 0, FSM IDLE, no gnt/rvalid.
- With REG_BANK_ARB_LOCK_EN: B locks and does 3 writes while A requests -> A is granted only after the B access with b_lock=0.
